xor_gate: RTL and testbench

XOR_GATE -- requirements
Module: xor_gate

---
 rtl/xor_gate.sv | 69 ++++++
 tb/tb_xor_gate.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/xor_gate.sv
`default_nettype none
// ============================================================================
// Module   : xor_gate
// Brief    : Bitwise XOR with registered copy and optional difference counter
//            (counter enabled by macro XOR_GATE_STATS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module xor_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    output logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] c_q,
    output logic [CNT_W-1:0] diff_cnt,
    output logic             sat
);

    logic [WIDTH-1:0] w_xor;
    logic [WIDTH-1:0] r_c_q;

    assign w_xor = a ^ b;
    assign c     = w_xor;
    assign c_q   = r_c_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_c_q <= '0;
        end else begin
            r_c_q <= w_xor;
        end
    end

`ifdef XOR_GATE_STATS_EN
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_diff_cnt;
    logic             w_at_max;

    assign w_at_max = (r_diff_cnt == C_CNT_MAX);

    // Reset outranks clear, clear outranks increment; hold at max instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_diff_cnt <= '0;
        end else if (cnt_clr) begin
            r_diff_cnt <= '0;
        end else if ((|w_xor) && !w_at_max) begin
            r_diff_cnt <= r_diff_cnt + C_CNT_ONE;
        end
    end

    assign diff_cnt = r_diff_cnt;
    assign sat      = w_at_max;
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr = cnt_clr;
    assign diff_cnt         = '0;
    assign sat              = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xor_gate.sv
`default_nettype none
// ============================================================================
// Module   : tb_xor_gate
// Brief    : Scoreboard bench for xor_gate at WIDTH=1/CNT_W=8 and WIDTH=4/CNT_W=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xor_gate;

`ifdef XOR_GATE_STATS_EN
    localparam bit C_STATS = 1'b1;
`else
    localparam bit C_STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       a, b, rst_n, cnt_clr;
    logic [3:0] a4, b4;
    logic       c, c_q, sat;
    logic [7:0] diff_cnt;
    logic [3:0] c4, c_q4, diff_cnt4;
    logic       sat4;

    xor_gate #(.WIDTH(1), .CNT_W(8)) u_dut (
        .c(c), .a(a), .b(b), .clk(clk), .rst_n(rst_n), .cnt_clr(cnt_clr),
        .c_q(c_q), .diff_cnt(diff_cnt), .sat(sat)
    );

    xor_gate #(.WIDTH(4), .CNT_W(4)) u_dut4 (
        .c(c4), .a(a4), .b(b4), .clk(clk), .rst_n(rst_n), .cnt_clr(cnt_clr),
        .c_q(c_q4), .diff_cnt(diff_cnt4), .sat(sat4)
    );

    typedef struct packed {
        logic       cq;
        logic [7:0] cnt;
        logic       sat;
        logic [3:0] cq4;
        logic [3:0] cnt4;
        logic       sat4;
    } exp_t;

    exp_t       sb_q[$];
    int         n_total = 0;
    int         n_bad   = 0;

    logic       m_cq;
    logic [7:0] m_cnt;
    logic [3:0] m_cq4;
    logic [3:0] m_cnt4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, check c combinationally, then check the edge result.
    task automatic cycle(input logic ia, input logic ib, input logic [3:0] ia4,
                         input logic [3:0] ib4, input logic irst_n, input logic iclr);
        exp_t e;
        a = ia; b = ib; a4 = ia4; b4 = ib4; rst_n = irst_n; cnt_clr = iclr;
        #1;
        chk("c", {31'b0, c}, {31'b0, ia ^ ib});
        chk("c4", {28'b0, c4}, {28'b0, ia4 ^ ib4});
        if (!irst_n) begin
            m_cq = 1'b0; m_cnt = 8'd0; m_cq4 = 4'd0; m_cnt4 = 4'd0;
        end else begin
            m_cq  = ia ^ ib;
            m_cq4 = ia4 ^ ib4;
            if (C_STATS) begin
                if (iclr) begin
                    m_cnt = 8'd0; m_cnt4 = 4'd0;
                end else begin
                    if ((ia != ib) && (m_cnt != 8'hFF)) m_cnt = m_cnt + 8'd1;
                    if ((ia4 != ib4) && (m_cnt4 != 4'hF)) m_cnt4 = m_cnt4 + 4'd1;
                end
            end
        end
        e.cq = m_cq; e.cnt = m_cnt; e.sat = C_STATS && (m_cnt == 8'hFF);
        e.cq4 = m_cq4; e.cnt4 = m_cnt4; e.sat4 = C_STATS && (m_cnt4 == 4'hF);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("c_q", {31'b0, c_q}, {31'b0, e.cq});
            chk("diff_cnt", {24'b0, diff_cnt}, {24'b0, e.cnt});
            chk("sat", {31'b0, sat}, {31'b0, e.sat});
            chk("c_q4", {28'b0, c_q4}, {28'b0, e.cq4});
            chk("diff_cnt4", {28'b0, diff_cnt4}, {28'b0, e.cnt4});
            chk("sat4", {31'b0, sat4}, {31'b0, e.sat4});
        end
    endtask

    initial begin
        logic [1:0] ab;
        a = 1'b1; b = 1'b0; a4 = 4'd0; b4 = 4'd0; rst_n = 1'b0; cnt_clr = 1'b1;
        m_cq = 1'b0; m_cnt = 8'd0; m_cq4 = 4'd0; m_cnt4 = 4'd0;
        @(posedge clk);
        #1;

        // Reset with clear and a!=b asserted together
        cycle(1'b1, 1'b0, 4'b1100, 4'b1010, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0);
        chk("rst_cq_const", {31'b0, c_q}, 32'd0);

        // Truth table
        for (int i = 0; i < 4; i++) begin
            ab = i[1:0];
            cycle(ab[1], ab[0], 4'b1100, 4'b1010, 1'b1, 1'b0);
        end
        chk("c4_const", {28'b0, c4}, 32'h6);

        // Registered path: 1^0 then 1^1
        cycle(1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        chk("cq_after_10", {31'b0, c_q}, 32'd1);
        cycle(1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
        chk("cq_after_11", {31'b0, c_q}, 32'd0);

        // Count 5 differing edges then 3 equal edges from a clear
        cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 4'd3, 4'd1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 4'd5, 4'd5, 1'b1, 1'b0);
        chk("cnt5", {24'b0, diff_cnt}, C_STATS ? 32'd5 : 32'd0);

        // Reset mid-count, then resume
        cycle(1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 4'd1, 4'd0, 1'b1, 1'b0);

        // Saturation: 300 differing edges plus one more
        for (int i = 0; i < 301; i++) cycle(1'b0, 1'b1, 4'd9, 4'd6, 1'b1, 1'b0);
        chk("sat_cnt", {24'b0, diff_cnt}, C_STATS ? 32'd255 : 32'd0);
        chk("sat_flag", {31'b0, sat}, C_STATS ? 32'd1 : 32'd0);

        // Clear alone keeps the registered path live
        cycle(1'b1, 1'b0, 4'd2, 4'd7, 1'b1, 1'b1);

        // Random mix
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 19) != 0), ($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
